// File: rtl/rs15_13_dec_serial.sv
// rtl/rs15_13_dec_serial.sv - serial RS(15,13) decoder over GF(16), single-symbol correction
module rs15_13_dec_serial (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  sym_i,
   input  logic        sym_valid_i,
   input  logic        sop_i,
   output logic [3:0]  data_o,
   output logic        data_valid_o,
   output logic        data_sop_o,
   output logic        cw_done_o,
   output logic        corrected_o,
   output logic        uncorrectable_o,
   output logic        err_frame_o,
   input  logic        cnt_clr_i,
   output logic [15:0] corr_cnt_o,
   output logic [15:0] uncorr_cnt_o
);

   typedef enum logic {S_IDLE, S_RECV} rx_state_t;

   // multiply by alpha modulo x^4+x+1
   function automatic logic [3:0] gf_mul_a(input logic [3:0] x);
      return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
   endfunction

   // discrete log base alpha; log(0) is meaningless and masked by the zero checks
   function automatic logic [3:0] gf_log(input logic [3:0] x);
      case (x)
         4'h1: return 4'd0;
         4'h2: return 4'd1;
         4'h3: return 4'd4;
         4'h4: return 4'd2;
         4'h5: return 4'd8;
         4'h6: return 4'd5;
         4'h7: return 4'd10;
         4'h8: return 4'd3;
         4'h9: return 4'd14;
         4'hA: return 4'd9;
         4'hB: return 4'd7;
         4'hC: return 4'd6;
         4'hD: return 4'd13;
         4'hE: return 4'd11;
         4'hF: return 4'd12;
         default: return 4'd0;
      endcase
   endfunction

   // alpha^n for n in 0..14
   function automatic logic [3:0] gf_alog(input logic [3:0] n);
      case (n)
         4'd0:  return 4'h1;
         4'd1:  return 4'h2;
         4'd2:  return 4'h4;
         4'd3:  return 4'h8;
         4'd4:  return 4'h3;
         4'd5:  return 4'h6;
         4'd6:  return 4'hC;
         4'd7:  return 4'hB;
         4'd8:  return 4'h5;
         4'd9:  return 4'hA;
         4'd10: return 4'h7;
         4'd11: return 4'hE;
         4'd12: return 4'hF;
         4'd13: return 4'hD;
         4'd14: return 4'h9;
         default: return 4'h1;
      endcase
   endfunction

   // reduce an exponent sum (at most 43) modulo 15
   function automatic logic [3:0] mod15(input logic [5:0] x);
      if (x >= 6'd30)
         return 4'(x - 6'd30);
      else if (x >= 6'd15)
         return 4'(x - 6'd15);
      else
         return x[3:0];
   endfunction

   rx_state_t  state;
   logic [3:0] cnt;
   logic [3:0] s1, s2;
   logic       bank;
   logic       done_bank;
   logic       dec_go;

   logic [3:0] bank0 [0:12];
   logic [3:0] bank1 [0:12];

   logic       wr_en;
   logic [3:0] wr_idx;

   logic       dec_fix, dec_unc;
   logic [3:0] dec_j, dec_e;
   logic       out_run;
   logic [3:0] out_k;

   logic       s1z, s2z;
   logic [3:0] l1, l2, loc_j, err_e;
   logic [3:0] rd_sym;
   logic       fix_hit;
   logic       done_now;

   // buffer write steering: sop always restarts at slot 0, slots 13/14 never stored
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = 4'd0;
      if (sym_valid_i && sop_i) begin
         wr_en  = 1'b1;
         wr_idx = 4'd0;
      end else if (sym_valid_i && state == S_RECV && cnt < 4'd13) begin
         wr_en  = 1'b1;
         wr_idx = cnt;
      end
   end

   // ping-pong data buffers, written by the receive side only
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (bank)
            bank1[wr_idx] <= sym_i;
         else
            bank0[wr_idx] <= sym_i;
      end
   end

   // receive FSM: framing, serial syndrome accumulation, bank hand-off
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= 4'd0;
         s1          <= 4'h0;
         s2          <= 4'h0;
         bank        <= 1'b0;
         done_bank   <= 1'b0;
         dec_go      <= 1'b0;
         err_frame_o <= 1'b0;
      end else begin
         dec_go      <= 1'b0;
         err_frame_o <= 1'b0;
         if (sym_valid_i) begin
            if (sop_i) begin
               err_frame_o <= (state == S_RECV);
               s1          <= sym_i;
               s2          <= sym_i;
               cnt         <= 4'd1;
               state       <= S_RECV;
            end else if (state == S_RECV) begin
               s1 <= gf_mul_a(s1) ^ sym_i;
               s2 <= gf_mul_a(gf_mul_a(s2)) ^ sym_i;
               if (cnt == 4'd14) begin
                  cnt       <= 4'd0;
                  state     <= S_IDLE;
                  dec_go    <= 1'b1;
                  done_bank <= bank;
                  bank      <= ~bank;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end else begin
               err_frame_o <= 1'b1;
            end
         end
      end
   end

   // error locator X=S2/S1 and value e=S1^2/S2 through log/antilog tables
   always_comb begin
      s1z   = (s1 == 4'h0);
      s2z   = (s2 == 4'h0);
      l1    = gf_log(s1);
      l2    = gf_log(s2);
      loc_j = mod15({2'b00, l2} + 6'd15 - {2'b00, l1});
      err_e = gf_alog(mod15({1'b0, l1, 1'b0} + 6'd15 - {2'b00, l2}));
   end

   // read side of the bank that just completed, plus correction match
   always_comb begin
      rd_sym   = done_bank ? bank1[out_k] : bank0[out_k];
      fix_hit  = dec_fix && ((4'd14 - out_k) == dec_j);
      done_now = out_run && (out_k == 4'd12);
   end

   // decode register stage followed by 13-cycle output burst
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dec_fix         <= 1'b0;
         dec_unc         <= 1'b0;
         dec_j           <= 4'd0;
         dec_e           <= 4'h0;
         out_run         <= 1'b0;
         out_k           <= 4'd0;
         data_o          <= 4'h0;
         data_valid_o    <= 1'b0;
         data_sop_o      <= 1'b0;
         cw_done_o       <= 1'b0;
         corrected_o     <= 1'b0;
         uncorrectable_o <= 1'b0;
      end else begin
         data_o          <= 4'h0;
         data_valid_o    <= 1'b0;
         data_sop_o      <= 1'b0;
         cw_done_o       <= 1'b0;
         corrected_o     <= 1'b0;
         uncorrectable_o <= 1'b0;
         if (dec_go) begin
            dec_fix <= !s1z && !s2z;
            dec_unc <= s1z ^ s2z;
            dec_j   <= loc_j;
            dec_e   <= err_e;
            out_run <= 1'b1;
            out_k   <= 4'd0;
         end else if (out_run) begin
            data_o       <= rd_sym ^ (fix_hit ? dec_e : 4'h0);
            data_valid_o <= 1'b1;
            data_sop_o   <= (out_k == 4'd0);
            if (out_k == 4'd12) begin
               out_run         <= 1'b0;
               cw_done_o       <= 1'b1;
               corrected_o     <= dec_fix;
               uncorrectable_o <= dec_unc;
            end else begin
               out_k <= out_k + 4'd1;
            end
         end
      end
   end

   // saturating statistics; clear has priority over a same-cycle increment
   always_ff @(posedge clk) begin
      if (!rst_n || cnt_clr_i) begin
         corr_cnt_o   <= 16'd0;
         uncorr_cnt_o <= 16'd0;
      end else if (done_now && !dec_go) begin
         if (dec_fix && corr_cnt_o != 16'hFFFF)
            corr_cnt_o <= corr_cnt_o + 16'd1;
         if (dec_unc && uncorr_cnt_o != 16'hFFFF)
            uncorr_cnt_o <= uncorr_cnt_o + 16'd1;
      end
   end

endmodule
